// File: rtl/mem_stage.sv
// mem_stage: memory-response stage of the in-order LoongArch pipeline.
//
// Holds one instruction coming from the EX/request stage. For a load it waits
// for the matching data-SRAM response, then extracts and sign/zero-extends the
// addressed byte, half or word. It presents the result to the writeback stage
// and on a forwarding bus to the issue stage. It also discards stale SRAM
// responses that belong to loads killed by a flush.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   ms_stall              hazard-unit hold (forces ms_allowin low)
//   ms_flush              hazard-unit flush (kills the held instruction)
//   ws_allowin            writeback stage can accept
//   ms_allowin            this stage can accept
//   es_to_ms_valid/bus    incoming instruction:
//                         {res_from_mem, load_op[2:0], addr_lo[1:0], gr_we,
//                          dest[4:0], alu_result[31:0], pc[31:0]}
//   data_sram_data_ok     response strobe for the oldest outstanding request
//   data_sram_rdata       response data
//   ms_to_ws_valid/bus    outgoing {gr_we, dest, final_result, pc}
//   ms_to_is_forward_bus  {fwd_en, fwd_pending, dest, final_result}
module mem_stage #(
    parameter int ES_TO_MS_BUS_WD = 76,
    parameter int MS_TO_WS_BUS_WD = 70,
    parameter int MS_FWD_BUS_WD   = 39
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ms_stall,
    input  logic                       ms_flush,
    input  logic                       ws_allowin,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    input  logic                       data_sram_data_ok,
    input  logic [31:0]                data_sram_rdata,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    output logic [MS_FWD_BUS_WD-1:0]   ms_to_is_forward_bus
);

    // Load extraction: pick the addressed lane, then sign- or zero-extend.
    // load_op[1:0]: 00 byte, 01 half, 10 word; load_op[2] selects unsigned.
    function automatic logic [31:0] load_extract(input logic [2:0]  op,
                                                 input logic [1:0]  lane,
                                                 input logic [31:0] word);
        logic signed [7:0]  byte_v;
        logic signed [15:0] half_v;
        logic [31:0]        res;
        case (lane)
            2'd0:    byte_v = word[7:0];
            2'd1:    byte_v = word[15:8];
            2'd2:    byte_v = word[23:16];
            default: byte_v = word[31:24];
        endcase
        half_v = lane[1] ? word[31:16] : word[15:0];
        case (op[1:0])
            2'b00:   res = op[2] ? {24'd0, byte_v} : 32'(byte_v);
            2'b01:   res = op[2] ? {16'd0, half_v} : 32'(half_v);
            default: res = word;
        endcase
        return res;
    endfunction

    logic                       ms_valid;
    logic [ES_TO_MS_BUS_WD-1:0] ms_bus;
    logic [31:0]                resp_buf;
    logic                       resp_buf_valid;
    logic                       drop_resp;

    logic        res_from_mem;
    logic [2:0]  load_op;
    logic [1:0]  addr_lo;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;

    assign {res_from_mem, load_op, addr_lo, gr_we, dest, alu_result, pc} = ms_bus;

    logic        resp_live;
    logic        ms_ready_go;
    logic        ms_leave;
    logic [31:0] load_word;
    logic [31:0] final_result;
    logic        fwd_en;
    logic        fwd_pending;

    // A response strobe while drop_resp is set belongs to a flushed load.
    assign resp_live   = data_sram_data_ok & ~drop_resp;
    assign ms_ready_go = ~res_from_mem | resp_live | resp_buf_valid;

    assign ms_allowin     = (~ms_valid | (ms_ready_go & ws_allowin)) & ~ms_stall;
    assign ms_to_ws_valid = ms_valid & ms_ready_go;
    // A stalled instruction stays put (ms_valid only updates on ms_allowin),
    // so its buffered response must survive the stall as well.
    assign ms_leave       = ms_to_ws_valid & ws_allowin & ~ms_stall;

    assign load_word    = resp_buf_valid ? resp_buf : data_sram_rdata;
    assign final_result = res_from_mem ? load_extract(load_op, addr_lo, load_word)
                                       : alu_result;

    assign fwd_en      = ms_valid & gr_we & (dest != 5'd0);
    assign fwd_pending = fwd_en & res_from_mem & ~ms_ready_go;

    // ---- EX -> MS boundary: instruction register ----
    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid <= 1'b0;
        end else if (ms_flush) begin
            ms_valid <= 1'b0;
        end else if (ms_allowin) begin
            ms_valid <= es_to_ms_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ms_bus <= '0;
        end else if (es_to_ms_valid & ms_allowin & ~ms_flush) begin
            ms_bus <= es_to_ms_bus;
        end
    end

    // Response buffer: captures the load data when WB cannot take it in the
    // cycle it arrives, since the SRAM only presents rdata for that one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_buf_valid <= 1'b0;
            resp_buf       <= '0;
        end else if (ms_flush | ms_leave) begin
            resp_buf_valid <= 1'b0;
        end else if (resp_live & ms_valid & res_from_mem & ~(ws_allowin & ~ms_stall)) begin
            resp_buf_valid <= 1'b1;
            resp_buf       <= data_sram_rdata;
        end
    end

    // Flushing a load whose response is still in flight leaves one stale
    // response to swallow. A response arriving in the flush cycle itself is
    // the flushed load's own, so nothing remains outstanding then.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_resp <= 1'b0;
        end else if (ms_flush & ms_valid & res_from_mem & ~resp_live & ~resp_buf_valid) begin
            drop_resp <= 1'b1;
        end else if (data_sram_data_ok & drop_resp) begin
            drop_resp <= 1'b0;
        end
    end

    // ---- MS -> WS / MS -> IS boundary ----
    assign ms_to_ws_bus         = {gr_we, dest, final_result, pc};
    assign ms_to_is_forward_bus = {fwd_en, fwd_pending, dest, final_result};

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage. Expected WB bus words are queued when an
// instruction is driven and compared when the stage hands it to WB.
module tb_mem_stage;

    logic        clk;
    logic        reset;
    logic        ms_stall;
    logic        ms_flush;
    logic        ws_allowin;
    logic        ms_allowin;
    logic        es_to_ms_valid;
    logic [75:0] es_to_ms_bus;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        ms_to_ws_valid;
    logic [69:0] ms_to_ws_bus;
    logic [38:0] fwd;

    mem_stage dut (
        .clk                  (clk),
        .reset                (reset),
        .ms_stall             (ms_stall),
        .ms_flush             (ms_flush),
        .ws_allowin           (ws_allowin),
        .ms_allowin           (ms_allowin),
        .es_to_ms_valid       (es_to_ms_valid),
        .es_to_ms_bus         (es_to_ms_bus),
        .data_sram_data_ok    (data_sram_data_ok),
        .data_sram_rdata      (data_sram_rdata),
        .ms_to_ws_valid       (ms_to_ws_valid),
        .ms_to_ws_bus         (ms_to_ws_bus),
        .ms_to_is_forward_bus (fwd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [69:0] sb[$];

    logic [2:0]  ld_ops  [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
    logic [1:0]  ld_lanes[4] = '{2'd3, 2'd3, 2'd2, 2'd2};
    logic [31:0] ld_exps [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_80FF};

    function automatic logic [75:0] mk(input logic rfm, input logic [2:0] op,
                                       input logic [1:0] lo, input logic we,
                                       input logic [4:0] dst, input logic [31:0] alu,
                                       input logic [31:0] pc);
        return {rfm, op, lo, we, dst, alu, pc};
    endfunction

    function automatic logic [69:0] wb(input logic we, input logic [4:0] dst,
                                       input logic [31:0] res, input logic [31:0] pc);
        return {we, dst, res, pc};
    endfunction

    task automatic chk(input string tag, input logic [75:0] obs, input logic [75:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at the falling edge: a transfer to WB happens at the next rising edge.
    task automatic sb_sample();
        logic [69:0] exp;
        if (ms_to_ws_valid && ws_allowin && !ms_stall && !reset) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $error("FAIL wb_unexpected: observed %h expected no transfer", ms_to_ws_bus);
            end else begin
                exp = sb.pop_front();
                chk("wb_bus", 76'(ms_to_ws_bus), 76'(exp));
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        sb_sample();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset             = 1'b1;
        ms_stall          = 1'b0;
        ms_flush          = 1'b0;
        ws_allowin        = 1'b1;
        es_to_ms_valid    = 1'b0;
        es_to_ms_bus      = '0;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = '0;
        step();
        step();
        settle();
        chk("rst_allowin", 76'(ms_allowin), 76'(1'b1));
        chk("rst_valid",   76'(ms_to_ws_valid), 76'(1'b0));
        chk("rst_wsbus",   76'(ms_to_ws_bus), 76'(0));
        chk("rst_fwd",     76'(fwd), 76'(0));
        reset = 1'b0;

        // ALU op
        es_to_ms_bus   = mk(1'b0, 3'b000, 2'd0, 1'b1, 5'd5, 32'h1234_5678, 32'h1c00_0000);
        es_to_ms_valid = 1'b1;
        sb.push_back(wb(1'b1, 5'd5, 32'h1234_5678, 32'h1c00_0000));
        settle();
        chk("alu_pre_valid", 76'(ms_to_ws_valid), 76'(1'b0));
        step();
        es_to_ms_valid = 1'b0;
        settle();
        chk("alu_valid", 76'(ms_to_ws_valid), 76'(1'b1));
        chk("alu_fwd",   76'(fwd), 76'({1'b1, 1'b0, 5'd5, 32'h1234_5678}));
        step();

        // Stall holds a ready ALU op
        es_to_ms_bus   = mk(1'b0, 3'b000, 2'd0, 1'b1, 5'd6, 32'hA5A5_A5A5, 32'h1c00_0004);
        es_to_ms_valid = 1'b1;
        sb.push_back(wb(1'b1, 5'd6, 32'hA5A5_A5A5, 32'h1c00_0004));
        step();
        es_to_ms_valid = 1'b0;
        ms_stall       = 1'b1;
        settle();
        chk("stall_allowin", 76'(ms_allowin), 76'(1'b0));
        step();
        ms_stall = 1'b0;
        settle();
        chk("stall_held", 76'(ms_to_ws_valid), 76'(1'b1));
        step();

        // Sub-word loads, response in the cycle after accept
        for (int i = 0; i < 4; i++) begin
            es_to_ms_bus   = mk(1'b1, ld_ops[i], ld_lanes[i], 1'b1, 5'd7, 32'h0,
                                32'(32'h1c00_0010 + 4 * i));
            es_to_ms_valid = 1'b1;
            sb.push_back(wb(1'b1, 5'd7, ld_exps[i], 32'(32'h1c00_0010 + 4 * i)));
            step();
            es_to_ms_valid    = 1'b0;
            data_sram_data_ok = 1'b1;
            data_sram_rdata   = 32'h80FF_0000;
            settle();
            chk("ld_valid",    76'(ms_to_ws_valid), 76'(1'b1));
            chk("ld_fwd_data", 76'(fwd[31:0]), 76'(ld_exps[i]));
            step();
            data_sram_data_ok = 1'b0;
        end

        // Load with a delayed response
        es_to_ms_bus   = mk(1'b1, 3'b010, 2'd0, 1'b1, 5'd9, 32'h0, 32'h1c00_0040);
        es_to_ms_valid = 1'b1;
        sb.push_back(wb(1'b1, 5'd9, 32'hCAFE_F00D, 32'h1c00_0040));
        step();
        es_to_ms_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("dly_valid",   76'(ms_to_ws_valid), 76'(1'b0));
            chk("dly_pending", 76'(fwd[37]), 76'(1'b1));
            chk("dly_allowin", 76'(ms_allowin), 76'(1'b0));
            step();
        end
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hCAFE_F00D;
        settle();
        chk("dly_ready",   76'(ms_to_ws_valid), 76'(1'b1));
        chk("dly_pending_clr", 76'(fwd[37]), 76'(1'b0));
        step();
        data_sram_data_ok = 1'b0;

        // Response arrives while WB is blocked; buffered value must be used
        es_to_ms_bus   = mk(1'b1, 3'b010, 2'd0, 1'b1, 5'd10, 32'h0, 32'h1c00_0050);
        es_to_ms_valid = 1'b1;
        sb.push_back(wb(1'b1, 5'd10, 32'hDEAD_BEEF, 32'h1c00_0050));
        step();
        es_to_ms_valid    = 1'b0;
        ws_allowin        = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hDEAD_BEEF;
        settle();
        chk("buf_ready", 76'(ms_to_ws_valid), 76'(1'b1));
        step();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h0BAD_F00D;
        settle();
        chk("buf_hold_valid", 76'(ms_to_ws_valid), 76'(1'b1));
        chk("buf_fwd",        76'(fwd[31:0]), 76'(32'hDEAD_BEEF));
        chk("buf_allowin",    76'(ms_allowin), 76'(1'b0));
        step();
        ws_allowin = 1'b1;
        settle();
        chk("buf_fwd_release", 76'(fwd[31:0]), 76'(32'hDEAD_BEEF));
        step();
        settle();
        chk("buf_drained", 76'(ms_to_ws_valid), 76'(1'b0));

        // Flush a waiting load; its late response must be dropped
        es_to_ms_bus   = mk(1'b1, 3'b010, 2'd0, 1'b1, 5'd11, 32'h0, 32'h1c00_0060);
        es_to_ms_valid = 1'b1;
        step();
        es_to_ms_valid = 1'b0;
        settle();
        chk("fl_wait", 76'(ms_to_ws_valid), 76'(1'b0));
        step();
        ms_flush = 1'b1;
        step();
        ms_flush = 1'b0;
        settle();
        chk("fl_killed",  76'(ms_to_ws_valid), 76'(1'b0));
        chk("fl_allowin", 76'(ms_allowin), 76'(1'b1));
        chk("fl_fwd_en",  76'(fwd[38]), 76'(1'b0));
        es_to_ms_bus   = mk(1'b1, 3'b010, 2'd0, 1'b1, 5'd12, 32'h0, 32'h1c00_0070);
        es_to_ms_valid = 1'b1;
        sb.push_back(wb(1'b1, 5'd12, 32'h2222_2222, 32'h1c00_0070));
        step();
        es_to_ms_valid    = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h1111_1111;
        settle();
        chk("drop_not_ready", 76'(ms_to_ws_valid), 76'(1'b0));
        chk("drop_pending",   76'(fwd[37]), 76'(1'b1));
        step();
        data_sram_data_ok = 1'b0;
        settle();
        chk("drop_wait", 76'(ms_to_ws_valid), 76'(1'b0));
        step();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h2222_2222;
        settle();
        chk("drop_ready",    76'(ms_to_ws_valid), 76'(1'b1));
        chk("drop_fwd_data", 76'(fwd[31:0]), 76'(32'h2222_2222));
        step();
        data_sram_data_ok = 1'b0;

        // Reset while holding a buffered response
        es_to_ms_bus   = mk(1'b1, 3'b010, 2'd0, 1'b1, 5'd13, 32'h0, 32'h1c00_0080);
        es_to_ms_valid = 1'b1;
        step();
        es_to_ms_valid    = 1'b0;
        ws_allowin        = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h55AA_55AA;
        step();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h0;
        settle();
        chk("rb_buffered", 76'(fwd[31:0]), 76'(32'h55AA_55AA));
        reset = 1'b1;
        step();
        reset      = 1'b0;
        ws_allowin = 1'b1;
        settle();
        chk("rst2_allowin", 76'(ms_allowin), 76'(1'b1));
        chk("rst2_valid",   76'(ms_to_ws_valid), 76'(1'b0));
        chk("rst2_wsbus",   76'(ms_to_ws_bus), 76'(0));
        chk("rst2_fwd",     76'(fwd), 76'(0));
        es_to_ms_bus   = mk(1'b1, 3'b010, 2'd0, 1'b1, 5'd14, 32'h0, 32'h1c00_0090);
        es_to_ms_valid = 1'b1;
        sb.push_back(wb(1'b1, 5'd14, 32'h1357_9BDF, 32'h1c00_0090));
        step();
        es_to_ms_valid    = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h1357_9BDF;
        settle();
        chk("post_rst_ready", 76'(ms_to_ws_valid), 76'(1'b1));
        step();
        data_sram_data_ok = 1'b0;
        step();

        chk("sb_empty", 76'(sb.size()), 76'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
